// File: rtl/sr_fetch.sv
// sr_fetch: in-order instruction fetch with a small response queue.
// Redirects flush the queue and drop responses still in flight.
module sr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e state_q, state_d;
  logic          drain;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pcs_q  [DEPTH];
  logic [31:0]   hold_instr_q, hold_pc_q;

  logic          req_fire, push, pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redir_pc;
  logic          unused_rpc;

  assign unused_rpc  = ^redirect_pc[1:0];
  assign redir_pc    = {redirect_pc[31:2], 2'b00};
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};

  assign imem_req_valid = !rst && !redirect_valid
                        && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  // When empty, the last presented head is held for decode.
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? word_q[head_q] : hold_instr_q;
  assign instr_pc    = instr_valid ? pcs_q[head_q]  : hold_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = instr_valid && instr_ready;
  assign push     = imem_rsp_valid && !redirect_valid && !drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_comb begin
    drain = (state_q == DRAIN);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && drain)
        drop_d = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        tail_d   = tail_q + AW'(1);
      end
      if (pop)
        head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      outst_q      <= '0;
      drop_q       <= '0;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      hold_instr_q <= instr;
      hold_pc_q    <= instr_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[tail_q] <= imem_rsp_data;
      pcs_q[tail_q]  <= rsp_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count_q == CW'(DEPTH)));

endmodule
